fp_addsub_pipe: RTL and testbench

Parametrised, 3-stage pipelined floating-point adder/subtractor with valid/ready handshake on both sides. Generalises the single-precision combinational add/sub to any IEEE-style EXP_W/MAN_W format. Adds round-to-nearest-even, overflow/underflow/zero flags and back-pressure. Sits between the operand-issue logic and the result writeback in the FP datapath.

---
 rtl/fp_addsub_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// 3-stage pipelined IEEE-style FP add/sub (align, add, normalise/round).
// Define FP_SPECIAL_EN to decode Inf/NaN inputs and add the invalid flag.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
`ifdef FP_SPECIAL_EN
    output logic [3:0]             out_flags
`else
    output logic [2:0]             out_flags
`endif
);

`ifdef FP_SPECIAL_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int XW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- stage 1: decode and align ----------------
    logic               w_sa, w_sb, w_a_big, w_sl, w_ss;
    logic [EXP_W-1:0]   w_ea, w_eb, w_el, w_es, w_diff;
    logic [MAN_W:0]     w_ma, w_mb, w_ml, w_ms;
    logic [XW-1:0]      w_ms_al;
    logic [2*XW-1:0]    w_wide;

    always_comb begin
        w_sa    = in_a[W-1];
        w_sb    = in_b[W-1] ^ in_sub;
        w_ea    = in_a[W-2:MAN_W];
        w_eb    = in_b[W-2:MAN_W];
        w_ma    = (w_ea != '0) ? {1'b1, in_a[MAN_W-1:0]} : '0;
        w_mb    = (w_eb != '0) ? {1'b1, in_b[MAN_W-1:0]} : '0;
        w_a_big = in_a[W-2:0] >= in_b[W-2:0];
        w_sl    = w_a_big ? w_sa : w_sb;
        w_ss    = w_a_big ? w_sb : w_sa;
        w_el    = w_a_big ? w_ea : w_eb;
        w_es    = w_a_big ? w_eb : w_ea;
        w_ml    = w_a_big ? w_ma : w_mb;
        w_ms    = w_a_big ? w_mb : w_ma;
        w_diff  = w_el - w_es;
        w_wide  = {w_ms, 3'b000, {XW{1'b0}}} >> w_diff;
        // bits pushed past the round position collapse into sticky
        if (32'(w_diff) >= XW)
            w_ms_al = {{(XW-1){1'b0}}, |w_ms};
        else
            w_ms_al = w_wide[2*XW-1:XW]
                    | {{(XW-1){1'b0}}, |w_wide[XW-1:0]};
    end

`ifdef FP_SPECIAL_EN
    logic w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic r_s1_spec, r_s1_nan, r_s1_isign;
    logic r_s2_spec, r_s2_nan, r_s2_isign;

    always_comb begin
        w_a_inf = (&w_ea) && (in_a[MAN_W-1:0] == '0);
        w_b_inf = (&w_eb) && (in_b[MAN_W-1:0] == '0);
        w_a_nan = (&w_ea) && (in_a[MAN_W-1:0] != '0);
        w_b_nan = (&w_eb) && (in_b[MAN_W-1:0] != '0);
    end
`endif

    logic               r_s1_valid, r_s1_sign, r_s1_sub;
    logic [EXP_W-1:0]   r_s1_exp;
    logic [XW-1:0]      r_s1_ml, r_s1_ms;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_sl;
            r_s1_sub   <= w_sl ^ w_ss;
            r_s1_exp   <= w_el;
            r_s1_ml    <= {w_ml, 3'b000};
            r_s1_ms    <= w_ms_al;
`ifdef FP_SPECIAL_EN
            r_s1_spec  <= w_a_inf | w_b_inf | w_a_nan | w_b_nan;
            r_s1_nan   <= w_a_nan | w_b_nan
                        | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
            r_s1_isign <= w_a_inf ? w_sa : w_sb;
`endif
        end
    end

    // ---------------- stage 2: add / subtract ----------------
    logic [XW:0] w_sum;

    always_comb begin
        if (r_s1_sub)
            w_sum = {1'b0, r_s1_ml} - {1'b0, r_s1_ms};
        else
            w_sum = {1'b0, r_s1_ml} + {1'b0, r_s1_ms};
    end

    logic               r_s2_valid, r_s2_sign;
    logic [EXP_W-1:0]   r_s2_exp;
    logic [XW:0]        r_s2_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= (w_sum == '0) ? 1'b0 : r_s1_sign;
            r_s2_exp   <= r_s1_exp;
            r_s2_sum   <= w_sum;
`ifdef FP_SPECIAL_EN
            r_s2_spec  <= r_s1_spec;
            r_s2_nan   <= r_s1_nan;
            r_s2_isign <= r_s1_isign;
`endif
        end
    end

    // ---------------- stage 3: normalise and round ----------------
    logic                   w_found, w_rup;
    logic [EW-1:0]          w_lz;
    logic signed [EW-1:0]   w_e_base, w_e3, w_e4;
    logic [XW-1:0]          w_norm;
    logic [MAN_W+1:0]       w_mr;
    logic [MAN_W-1:0]       w_frac;
    logic [W-1:0]           w_res;
    logic [FW-1:0]          w_flags;

    always_comb begin
        w_found = 1'b0;
        w_lz    = '0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (r_s2_sum[i])
                    w_found = 1'b1;
                else
                    w_lz = w_lz + EW'(1);
            end
        end
        w_e_base = $signed({2'b00, r_s2_exp});
        if (r_s2_sum[XW]) begin
            w_norm = {r_s2_sum[XW:2], r_s2_sum[1] | r_s2_sum[0]};
            w_e3   = w_e_base + $signed(EW'(1));
        end else begin
            w_norm = r_s2_sum[XW-1:0] << w_lz;
            w_e3   = w_e_base - $signed(w_lz);
        end
        w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mr  = {1'b0, w_norm[XW-1:3]} + (MAN_W+2)'(w_rup);
        if (w_mr[MAN_W+1]) begin
            w_frac = w_mr[MAN_W:1];
            w_e4   = w_e3 + $signed(EW'(1));
        end else begin
            w_frac = w_mr[MAN_W-1:0];
            w_e4   = w_e3;
        end

        w_flags = '0;
        if (r_s2_sum == '0) begin
            w_res        = '0;
            w_flags[2:0] = 3'b001;
        end else if (w_e4 >= EMAX) begin
            w_res        = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[2:0] = 3'b100;
        end else if (w_e4[EW-1] || w_e4 == '0) begin
            w_res        = '0;
            w_flags[2:0] = 3'b011;
        end else begin
            w_res = {r_s2_sign, w_e4[EXP_W-1:0], w_frac};
        end
`ifdef FP_SPECIAL_EN
        if (r_s2_spec) begin
            w_flags = '0;
            if (r_s2_nan) begin
                w_res      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_flags[3] = 1'b1;
            end else begin
                w_res = {r_s2_isign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end
`endif
    end

    logic               r_out_valid;
    logic [W-1:0]       r_out_result;
    logic [FW-1:0]      r_out_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_result <= w_res;
                r_out_flags  <= w_flags;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary32), exact-arithmetic reference.
module tb_fp_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, in_sub;
    logic        out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  out_flags;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    logic done;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // exact sum of the two values, then one round-to-nearest-even
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        exp_t         r;
        logic         bs, sl, ss;
        logic [31:0]  l, s;
        int           el, es, d, p, e, sh;
        logic [127:0] ra, rb, rs, qq, rem, half;
        bs    = b[31] ^ sub;
        r.res = '0;
        r.flg = 3'b001;
        if (a[30:23] == 0 && b[30:23] == 0) return r;
        if (a[30:23] == 0) begin
            r.res = {bs, b[30:0]}; r.flg = 3'b000; return r;
        end
        if (b[30:23] == 0) begin
            r.res = a; r.flg = 3'b000; return r;
        end
        if (a[30:0] >= b[30:0]) begin
            l = a; sl = a[31]; s = b; ss = bs;
        end else begin
            l = b; sl = bs; s = a; ss = a[31];
        end
        el = int'(l[30:23]);
        es = int'(s[30:23]);
        d  = el - es;
        if (d > 40) begin
            r.res = {sl, l[30:0]}; r.flg = 3'b000; return r;
        end
        ra = 128'({1'b1, l[22:0]}) << d;
        rb = 128'({1'b1, s[22:0]});
        rs = (sl == ss) ? ra + rb : ra - rb;
        if (rs == 0) return r;
        p = 0;
        for (int i = 0; i < 128; i++) if (rs[i]) p = i;
        e = es + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            qq   = rs >> sh;
            rem  = rs & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && qq[0])) qq = qq + 128'd1;
            if (qq[24]) begin
                qq = qq >> 1;
                e  = e + 1;
            end
        end else begin
            qq = rs << (23 - p);
        end
        if (e >= 255) begin
            r.res = {sl, 8'hFF, 23'h0}; r.flg = 3'b100;
        end else if (e <= 0) begin
            r.res = '0; r.flg = 3'b011;
        end else begin
            r.res = {sl, e[7:0], qq[22:0]}; r.flg = 3'b000;
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input exp_t e);
        int waited = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        #4;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #4;
            waited++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
        end
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        issue(a, b, s, model(a, b, s));
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_left", 64'(q.size()), 64'd0);
    endtask

    // monitor: sampled just before the edge that would consume the output
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious: got %h/%b, required no output",
                             out_result, out_flags);
                end else begin
                    check(out_ready ? "result" : "held",
                          64'({out_result, out_flags}),
                          64'({q[0].res, q[0].flg}));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        int          k, ea, eb, base;
        logic [31:0] a, b;
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h3F800000, 32'h40000000, 1'b0, '{32'h40400000, 3'b000});
        @(posedge clk); #1;
        check("latency_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency_3", 64'(out_valid), 64'd1);

        issue(32'h3F800000, 32'h3F800000, 1'b1, '{32'h00000000, 3'b001});
        issue(32'h3F800001, 32'h33800000, 1'b0, '{32'h3F800002, 3'b000});
        issue(32'h3F800000, 32'h33800000, 1'b0, '{32'h3F800000, 3'b000});
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, '{32'h7F800000, 3'b100});
        issue(32'h00800001, 32'h00800000, 1'b1, '{32'h00000000, 3'b011});
        drain();

        base = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    issue_m(32'h40000000 + (32'(i) << 20),
                            32'h3FC00000 + (32'(i) << 9), 1'(i));
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #4;
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 64'(n_out - base), 64'd5);

        issue_m(32'h40490FDB, 32'h3F800000, 1'b0);
        issue_m(32'hC0000000, 32'h3E800000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check("rst_flight_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        repeat (5) begin
            @(posedge clk); #1;
            check("rst_idle", 64'(out_valid), 64'd0);
        end
        check("rst_none_out", 64'(n_out - base), 64'd0);

        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    k  = int'($urandom_range(0, 9));
                    ea = int'($urandom_range(1, 254));
                    case (k)
                        0: eb = 0;
                        1: eb = int'($urandom_range(1, 254));
                        2, 3: begin
                            ea = int'($urandom_range(250, 254));
                            eb = int'($urandom_range(250, 254));
                        end
                        4: begin
                            ea = int'($urandom_range(1, 4));
                            eb = int'($urandom_range(1, 4));
                        end
                        default: begin
                            eb = ea + int'($urandom_range(0, 60)) - 30;
                            if (eb < 1) eb = 1;
                            if (eb > 254) eb = 254;
                        end
                    endcase
                    a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
                    b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
                    if (k == 5) b = a;
                    if (k == 6) b = {a[31:8], 8'($urandom)};
                    issue_m(a, b, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 4) == 0) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
